vga_tile_renderer: RTL and testbench
====================================

# vga_tile_renderer

Pixel-pipeline stage directly downstream of `vga_buffer`. It converts the sync generator's pixel coordinates into a tile address on the buffer's video read port (`vr_addr_i`). It decodes the returned 28-bit tile word (`dout_o`) into a 4-bit-per-channel RGB pixel using a fixed set of procedural patterns, with per-tile blinking. Sync signals are delayed so they stay aligned with the rendered pixels.

## Interface
- `H_ACTIVE`, 640: visible pixels per line.
- `V_ACTIVE`, 480: visible lines per frame.
- `BLINK_BIT`, 5: frame-counter bit used as the blink phase (toggles every 32 frames).
- `clk_i` input 1: pixel clock; the only clock.
- `rstn_i` input 1: reset, asynchronous, active-low.
- `hcount_i` input 10: current pixel x from the sync generator.
- `vcount_i` input 10: current pixel y.
- `active_i` input 1: high inside the visible area.
- `hsync_i`, `vsync_i` input 1 each: active-low syncs, aligned with `hcount_i`.
- `tile_data_i` input 28: connects to `vga_buffer.dout_o`; valid one cycle after `vr_addr_o`.
- `vr_addr_o` output 10: connects to `vga_buffer.vr_addr_i`; tile index 0..599.
- `red_o`, `green_o`, `blue_o` output 4 each: pixel colour.
- `hsync_o`, `vsync_o` output 1 each: delayed syncs.

## Operation
- Tile grid is 40 columns × 15 rows, each tile 16×32 px.
  - col = `hcount_i[9:4]`, row = `vcount_i[9:5]`.
  - addr = row*40 + col, computed as (row<<5)+(row<<3)+col in 10 bits; maximum 599.
- Tile word fields:
  - [11:0] fg RGB444 (R=[11:8]).
  - [23:12] bg RGB444.
  - [26:24] pattern id.
  - [27] blink enable.
- Patterns, with x = pixel x within tile (0..15) and y = pixel y within tile (0..31). A pixel takes fg when the condition holds, otherwise bg:
  - 0: never (solid bg).
  - 1: always (solid fg).
  - 2: y[2].
  - 3: x[1].
  - 4: x[2]^y[2].
  - 5: x==0 or x==15 or y==0 or y==31.
  - 6: x==y[4:1].
  - 7: y>=30.
- Blink: if [27]=1 and `frame_cnt[BLINK_BIT]`=1, the pixel is forced to bg.
- Frame counter: 8 bits, increments on each `vsync_i` falling edge (detected with a registered copy), wraps 255→0.
- Outside the active area (`active_i`=0, or coordinates ≥ H_ACTIVE/V_ACTIVE):
  - `vr_addr_o` is driven to 0.
  - The pixel output is 0x000 regardless of tile data.

## Timing
- Stage 1 (edge N):
  - Register `vr_addr_o` from `hcount_i`/`vcount_i`.
  - Register x, y, active and syncs.
- Stage 2 (edge N+1): the buffer presents `tile_data_i`; the block registers the tile word plus the piped x, y, active and syncs.
- Stage 3 (edge N+2): register RGB and syncs.
- Total latency from coordinate input to RGB and sync outputs is 3 cycles. Syncs use the same 3-stage delay, so pixel and sync stay aligned.
- Blink phase is sampled in stage 3. A frame-counter change lands on a pixel boundary, never mid-pixel.
- Reset state (asynchronous, immediate):
  - `vr_addr_o`=0, RGB=0.
  - `hsync_o`=`vsync_o`=1 (inactive).
  - All pipeline valid/active flags=0, frame counter=0.
- Reset deasserted mid-frame: outputs stay black until valid data has propagated through all 3 stages. No partial pixel is emitted.
- No handshake exists: the block assumes the buffer's video read port is never stalled, since buffer writes do not block video reads.

## Structure
- Shared `vga_pkg` header holds:
  - H_ACTIVE, V_ACTIVE, TILE_W=16, TILE_H=32, COLS=40, ROWS=15, NUM_TILES=600.
  - Tile word field offsets (FG_LSB=0, BG_LSB=12, PAT_LSB=24, BLINK_BIT_POS=27).
  - The `vga_buffer` also uses this header.
- Sub-module `vga_tile_pattern`: combinational; inputs are pattern id, x, y; output is the fg-select bit. It is instantiated in stage 3.

## Test plan
- Reset: hold `rstn_i`=0 with random inputs. Expect `vr_addr_o`=0, RGB=0, syncs=1. Release reset; expect black output for the first 3 cycles.
- Address map: `hcount_i`=17, `vcount_i`=33, `active_i`=1 → `vr_addr_o`=41 after 1 cycle. (639,479) → 599. `active_i`=0 → 0.
- Solid/colour: model the buffer with a 1-cycle registered read; tile 0 = {blink 0, pat 1, bg 0x000, fg 0xF00}. For all pixels (0..15, 0..31), RGB=F,0,0 exactly 3 cycles after the coordinate.
- Checkerboard: pat 4, fg 0x0F0, bg 0x00F at tile 1. Pixel (16,0) → blue 0xF; (20,0) → green 0xF; (20,4) → blue 0xF.
- Blink: pat 1, blink=1, fg 0xFFF, bg 0x000. Frames 0–31 → white; frames 32–63 → black; frame 256 wraps → white.
- Sync alignment: a sync pulse at cycle T appears on `hsync_o` at T+3. Assert reset mid-line → outputs go to reset values immediately, and no glitch occurs after release.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants for the tile-based VGA path (buffer and renderer).
package vga_pkg;

    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;
    localparam int TILE_W    = 16;
    localparam int TILE_H    = 32;
    localparam int COLS      = 40;
    localparam int ROWS      = 15;
    localparam int NUM_TILES = 600;

    localparam int TILE_WORD_W   = 28;
    localparam int FG_LSB        = 0;
    localparam int BG_LSB        = 12;
    localparam int PAT_LSB       = 24;
    localparam int BLINK_BIT_POS = 27;

    typedef logic [11:0] rgb444_t;
    typedef logic [2:0]  pat_id_t;

    // row*40 + col without a multiplier; max 14*40+39 = 599 fits in 10 bits
    function automatic logic [9:0] tile_addr(input logic [4:0] row, input logic [5:0] col);
        return (10'(row) << 5) + (10'(row) << 3) + 10'(col);
    endfunction

endpackage

// File: rtl/vga_tile_pattern.sv
// Procedural tile patterns: decides fg/bg for a pixel from its in-tile position.
module vga_tile_pattern
    import vga_pkg::*;
(
    input  pat_id_t    pat_i,
    input  logic [3:0] x_i,
    input  logic [4:0] y_i,
    output logic       fg_sel_o
);

    // Pattern decode; unknown ids cannot occur since all 8 are defined
    always_comb begin
        fg_sel_o = 1'b0;
        case (pat_i)
            3'd0:    fg_sel_o = 1'b0;
            3'd1:    fg_sel_o = 1'b1;
            3'd2:    fg_sel_o = y_i[2];
            3'd3:    fg_sel_o = x_i[1];
            3'd4:    fg_sel_o = x_i[2] ^ y_i[2];
            3'd5:    fg_sel_o = (x_i == 4'd0) || (x_i == 4'd15) || (y_i == 5'd0) || (y_i == 5'd31);
            3'd6:    fg_sel_o = (x_i == y_i[4:1]);
            3'd7:    fg_sel_o = (y_i >= 5'd30);
            default: fg_sel_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/vga_tile_renderer.sv
// Tile renderer: coordinate -> tile address, tile word -> RGB444 pixel,
// with syncs delayed by the same 3 stages so pixel and sync stay aligned.
module vga_tile_renderer #(
    parameter int H_ACTIVE  = vga_pkg::H_ACTIVE,
    parameter int V_ACTIVE  = vga_pkg::V_ACTIVE,
    parameter int BLINK_BIT = 5
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [9:0]  hcount_i,
    input  logic [9:0]  vcount_i,
    input  logic        active_i,
    input  logic        hsync_i,
    input  logic        vsync_i,
    input  logic [27:0] tile_data_i,
    output logic [9:0]  vr_addr_o,
    output logic [3:0]  red_o,
    output logic [3:0]  green_o,
    output logic [3:0]  blue_o,
    output logic        hsync_o,
    output logic        vsync_o
);
    import vga_pkg::*;

    localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
    localparam logic [9:0] V_LIM = 10'(V_ACTIVE);

    logic       in_range;
    logic [9:0] vr_addr_d, vr_addr_q;
    logic [3:0] x1_q, x2_q;
    logic [4:0] y1_q, y2_q;
    logic       act1_q, act2_q;
    logic       hs1_q, hs2_q, hs3_q;
    logic       vs1_q, vs2_q, vs3_q;
    logic       vsync_prev_q;
    logic [7:0] frame_cnt_d, frame_cnt_q;
    rgb444_t    fg, bg, rgb_d, rgb_q;
    pat_id_t    pat;
    logic       blink_en, fg_sel;

    // Stage 1 address decode; off-screen coordinates read tile 0
    always_comb begin
        in_range  = active_i && (hcount_i < H_LIM) && (vcount_i < V_LIM);
        vr_addr_d = in_range ? tile_addr(vcount_i[9:5], hcount_i[9:4]) : '0;
    end

    // Stage 1 registers: buffer address plus in-tile position, valid and syncs
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vr_addr_q <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            act1_q    <= 1'b0;
            hs1_q     <= 1'b1;
            vs1_q     <= 1'b1;
        end else begin
            vr_addr_q <= vr_addr_d;
            x1_q      <= hcount_i[3:0];
            y1_q      <= vcount_i[4:0];
            act1_q    <= in_range;
            hs1_q     <= hsync_i;
            vs1_q     <= vsync_i;
        end
    end

    // Stage 2 registers: the buffer's registered read supplies the tile word meanwhile
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            x2_q   <= '0;
            y2_q   <= '0;
            act2_q <= 1'b0;
            hs2_q  <= 1'b1;
            vs2_q  <= 1'b1;
        end else begin
            x2_q   <= x1_q;
            y2_q   <= y1_q;
            act2_q <= act1_q;
            hs2_q  <= hs1_q;
            vs2_q  <= vs1_q;
        end
    end

    assign fg       = tile_data_i[FG_LSB +: 12];
    assign bg       = tile_data_i[BG_LSB +: 12];
    assign pat      = tile_data_i[PAT_LSB +: 3];
    assign blink_en = tile_data_i[BLINK_BIT_POS];

    vga_tile_pattern u_pattern (
        .pat_i    (pat),
        .x_i      (x2_q),
        .y_i      (y2_q),
        .fg_sel_o (fg_sel)
    );

    // Stage 3 colour select; blink phase forces background, blanking forces black
    always_comb begin
        rgb_d = '0;
        if (act2_q) begin
            rgb_d = (fg_sel && !(blink_en && frame_cnt_q[BLINK_BIT])) ? fg : bg;
        end
    end

    // Stage 3 output registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rgb_q <= '0;
            hs3_q <= 1'b1;
            vs3_q <= 1'b1;
        end else begin
            rgb_q <= rgb_d;
            hs3_q <= hs2_q;
            vs3_q <= vs2_q;
        end
    end

    assign frame_cnt_d = frame_cnt_q + {7'd0, vsync_prev_q & ~vsync_i};

    // Frame counter on vsync falling edge; updates only at a clock edge so blink never splits a pixel
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vsync_prev_q <= 1'b1;
            frame_cnt_q  <= '0;
        end else begin
            vsync_prev_q <= vsync_i;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign vr_addr_o = vr_addr_q;
    assign red_o     = rgb_q[11:8];
    assign green_o   = rgb_q[7:4];
    assign blue_o    = rgb_q[3:0];
    assign hsync_o   = hs3_q;
    assign vsync_o   = vs3_q;

endmodule

// File: tb/tb_vga_tile_renderer.sv
module tb_vga_tile_renderer;

    logic        clk = 1'b0;
    logic        rstn;
    logic [9:0]  hcount, vcount;
    logic        active, hsync, vsync;
    logic [27:0] tile_data = '0;
    logic [9:0]  vr_addr;
    logic [3:0]  red, green, blue;
    logic        hsync_o, vsync_o;

    always #5 clk = ~clk;

    vga_tile_renderer dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .hcount_i    (hcount),
        .vcount_i    (vcount),
        .active_i    (active),
        .hsync_i     (hsync),
        .vsync_i     (vsync),
        .tile_data_i (tile_data),
        .vr_addr_o   (vr_addr),
        .red_o       (red),
        .green_o     (green),
        .blue_o      (blue),
        .hsync_o     (hsync_o),
        .vsync_o     (vsync_o)
    );

    // buffer model: one-cycle registered read
    logic [27:0] mem [0:599];
    always @(posedge clk) tile_data <= (vr_addr < 10'd600) ? mem[vr_addr] : 28'h0;

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } exp_t;

    exp_t       sb_q[$];
    int         pass_cnt = 0;
    int         total_cnt = 0;
    logic [7:0] frames = 8'd0;

    function automatic logic [11:0] model_pix(input int h, input int v, input logic act, input logic [7:0] fr);
        int x, y;
        logic [27:0] w;
        bit sel;
        if (!act || h >= 640 || v >= 480) return 12'h000;
        x = h % 16;
        y = v % 32;
        w = mem[(v / 32) * 40 + h / 16];
        case (int'(w[26:24]))
            0:       sel = 0;
            1:       sel = 1;
            2:       sel = (y % 8) >= 4;
            3:       sel = ((x / 2) % 2) == 1;
            4:       sel = ((x / 4) % 2) != ((y / 4) % 2);
            5:       sel = (x == 0) || (x == 15) || (y == 0) || (y == 31);
            6:       sel = (x == y / 2);
            default: sel = (y >= 30);
        endcase
        if (w[27] && fr[5]) sel = 0;
        return sel ? w[11:0] : w[23:12];
    endfunction

    task automatic drive_pix(input int h, input int v, input logic act, input logic hs, input logic vs);
        exp_t e;
        hcount = 10'(h);
        vcount = 10'(v);
        active = act;
        hsync  = hs;
        vsync  = vs;
        e.rgb = model_pix(h, v, act, frames);
        e.hs  = hs;
        e.vs  = vs;
        sb_q.push_back(e);
    endtask

    task automatic prefill_idle();
        exp_t e;
        sb_q.delete();
        e.rgb = 12'h000;
        e.hs  = 1'b1;
        e.vs  = 1'b1;
        repeat (3) sb_q.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        rstn = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            hcount = 10'($urandom_range(0, 1023));
            vcount = 10'($urandom_range(0, 1023));
            active = 1'($urandom);
            hsync  = 1'($urandom);
            vsync  = 1'($urandom);
            #1;
            total_cnt++;
            if ({vr_addr, red, green, blue, hsync_o, vsync_o} !== {10'd0, 12'h000, 2'b11})
                $display("FAIL reset_hold got addr=%0d rgb=%h%h%h hs=%b vs=%b exp addr=0 rgb=000 hs=1 vs=1",
                         vr_addr, red, green, blue, hsync_o, vsync_o);
            else pass_cnt++;
        end
        frames = 8'd0;
        prefill_idle();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 0) rstn = 1'b1;
            e = sb_q.pop_front();
            total_cnt++;
            if ({red, green, blue, hsync_o, vsync_o} !== e)
                $display("FAIL reset_release i=%0d got %h exp %h", i, {red, green, blue, hsync_o, vsync_o}, e);
            else pass_cnt++;
            drive_pix(i, 0, 1'b1, 1'b1, 1'b1);
        end
        repeat (3) begin
            @(negedge clk);
            e = sb_q.pop_front();
            total_cnt++;
            if ({red, green, blue, hsync_o, vsync_o} !== e)
                $display("FAIL reset_drain got %h exp %h", {red, green, blue, hsync_o, vsync_o}, e);
            else pass_cnt++;
            drive_pix(0, 0, 1'b0, 1'b1, 1'b1);
        end
    endtask

    task automatic test_addr();
        int tab_h [6] = '{17, 639, 17, 640, 5, 300};
        int tab_v [6] = '{33, 479, 33, 10, 480, 200};
        bit tab_a [6] = '{1, 1, 0, 1, 1, 1};
        int exp_addr;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            hcount = 10'(tab_h[i]);
            vcount = 10'(tab_v[i]);
            active = tab_a[i];
            hsync  = 1'b1;
            vsync  = 1'b1;
            exp_addr = (tab_a[i] && tab_h[i] < 640 && tab_v[i] < 480) ? (tab_v[i] / 32) * 40 + tab_h[i] / 16 : 0;
            @(negedge clk);
            total_cnt++;
            if (vr_addr !== 10'(exp_addr))
                $display("FAIL addr (%0d,%0d,a=%0d) got %0d exp %0d", tab_h[i], tab_v[i], tab_a[i], vr_addr, exp_addr);
            else pass_cnt++;
        end
    endtask

    // sweep every pixel of tiles first..last (row 0) through the scoreboard
    task automatic test_tiles(input int first, input int last, input string name);
        exp_t e;
        sb_q.delete();
        for (int t = first; t <= last; t++)
            for (int y = 0; y < 32; y++)
                for (int x = 0; x < 16; x++) begin
                    @(negedge clk);
                    if (sb_q.size() == 3) begin
                        e = sb_q.pop_front();
                        total_cnt++;
                        if ({red, green, blue, hsync_o, vsync_o} !== e)
                            $display("FAIL %s t=%0d x=%0d y=%0d got %h exp %h", name, t, x, y,
                                     {red, green, blue, hsync_o, vsync_o}, e);
                        else pass_cnt++;
                    end
                    drive_pix(t * 16 + x, y, 1'b1, 1'b1, 1'b1);
                end
        repeat (3) begin
            @(negedge clk);
            e = sb_q.pop_front();
            total_cnt++;
            if ({red, green, blue, hsync_o, vsync_o} !== e)
                $display("FAIL %s_drain got %h exp %h", name, {red, green, blue, hsync_o, vsync_o}, e);
            else pass_cnt++;
            drive_pix(0, 0, 1'b0, 1'b1, 1'b1);
        end
    endtask

    task automatic test_checker();
        int ph [3] = '{16, 20, 20};
        int pv [3] = '{0, 0, 4};
        logic [11:0] want [3] = '{12'h00F, 12'h0F0, 12'h00F};
        exp_t e;
        prefill_idle();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            e = sb_q.pop_front();
            total_cnt++;
            if (i >= 3 && {red, green, blue} !== want[i - 3])
                $display("FAIL checker_px (%0d,%0d) got %h exp %h", ph[i - 3], pv[i - 3], {red, green, blue}, want[i - 3]);
            else if ({red, green, blue, hsync_o, vsync_o} !== e)
                $display("FAIL checker_sb got %h exp %h", {red, green, blue, hsync_o, vsync_o}, e);
            else pass_cnt++;
            if (i < 3) drive_pix(ph[i], pv[i], 1'b1, 1'b1, 1'b1);
            else       drive_pix(0, 0, 1'b0, 1'b1, 1'b1);
        end
        test_tiles(1, 1, "checker");
    endtask

    task automatic test_sync();
        exp_t e;
        logic hs, vs;
        sb_q.delete();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sb_q.size() == 3) begin
                e = sb_q.pop_front();
                total_cnt++;
                if ({red, green, blue, hsync_o, vsync_o} !== e)
                    $display("FAIL sync i=%0d got %h exp %h", i, {red, green, blue, hsync_o, vsync_o}, e);
                else pass_cnt++;
            end
            hs = (i % 7 == 3) ? 1'b0 : 1'b1;
            vs = (i == 20) ? 1'b0 : 1'b1;
            drive_pix((i * 37) % 700, (i * 53) % 520, (i % 5) != 0, hs, vs);
            if (i == 20) frames = frames + 8'd1;
        end
        // asynchronous reset between edges, mid-line
        #2 rstn = 1'b0;
        #1;
        total_cnt++;
        if ({vr_addr, red, green, blue, hsync_o, vsync_o} !== {10'd0, 12'h000, 2'b11})
            $display("FAIL midline_reset got addr=%0d rgb=%h%h%h hs=%b vs=%b exp addr=0 rgb=000 hs=1 vs=1",
                     vr_addr, red, green, blue, hsync_o, vsync_o);
        else pass_cnt++;
        frames = 8'd0;
        repeat (2) @(negedge clk);
        prefill_idle();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) rstn = 1'b1;
            e = sb_q.pop_front();
            total_cnt++;
            if ({red, green, blue, hsync_o, vsync_o} !== e)
                $display("FAIL sync_after_reset i=%0d got %h exp %h", i, {red, green, blue, hsync_o, vsync_o}, e);
            else pass_cnt++;
            drive_pix(580 + i * 3, 470 + i, 1'b1, (i % 4 == 1) ? 1'b0 : 1'b1, 1'b1);
        end
        repeat (3) begin
            @(negedge clk);
            e = sb_q.pop_front();
            total_cnt++;
            if ({red, green, blue, hsync_o, vsync_o} !== e)
                $display("FAIL sync_drain got %h exp %h", {red, green, blue, hsync_o, vsync_o}, e);
            else pass_cnt++;
            drive_pix(0, 0, 1'b0, 1'b1, 1'b1);
        end
    endtask

    task automatic test_blink();
        int targets [7] = '{0, 31, 32, 63, 64, 255, 256};
        logic [11:0] want [7] = '{12'hFFF, 12'hFFF, 12'h000, 12'h000, 12'hFFF, 12'h000, 12'hFFF};
        int done = 0;
        exp_t e;
        for (int p = 0; p < 7; p++) begin
            while (done < targets[p]) begin
                @(negedge clk);
                hcount = 10'd0; vcount = 10'd0; active = 1'b0; hsync = 1'b1; vsync = 1'b0;
                @(negedge clk);
                vsync = 1'b1;
                frames = frames + 8'd1;
                done++;
            end
            repeat (4) @(negedge clk);
            prefill_idle();
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                e = sb_q.pop_front();
                total_cnt++;
                if (i == 3 && {red, green, blue} !== want[p])
                    $display("FAIL blink frame=%0d got %h exp %h", targets[p], {red, green, blue}, want[p]);
                else if ({red, green, blue, hsync_o, vsync_o} !== e)
                    $display("FAIL blink_sb frame=%0d got %h exp %h", targets[p], {red, green, blue, hsync_o, vsync_o}, e);
                else pass_cnt++;
                if (i == 0) drive_pix(40, 3, 1'b1, 1'b1, 1'b1);
                else        drive_pix(0, 0, 1'b0, 1'b1, 1'b1);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 600; i++) mem[i] = 28'h0;
        mem[0]   = {1'b0, 3'd1, 12'h000, 12'hF00};
        mem[1]   = {1'b0, 3'd4, 12'h00F, 12'h0F0};
        mem[2]   = {1'b1, 3'd1, 12'h000, 12'hFFF};
        mem[3]   = {1'b0, 3'd2, 12'h1C7, 12'h5A3};
        mem[4]   = {1'b0, 3'd3, 12'h1C7, 12'h5A3};
        mem[5]   = {1'b0, 3'd5, 12'h1C7, 12'h5A3};
        mem[6]   = {1'b0, 3'd6, 12'h1C7, 12'h5A3};
        mem[7]   = {1'b0, 3'd7, 12'h1C7, 12'h5A3};
        mem[8]   = {1'b0, 3'd0, 12'h1C7, 12'h5A3};
        mem[599] = {1'b0, 3'd5, 12'h321, 12'hE6B};
        mem[598] = {1'b0, 3'd6, 12'h0A0, 12'hB0B};
        mem[559] = {1'b0, 3'd4, 12'h777, 12'h888};
        rstn = 1'b0; hcount = '0; vcount = '0; active = 1'b0; hsync = 1'b1; vsync = 1'b1;

        test_reset();
        test_addr();
        test_tiles(0, 0, "solid");
        test_checker();
        test_tiles(3, 8, "pattern");
        test_sync();
        test_blink();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
